// File: rtl/reply_tx_ctrl_pkg.sv
// Shared definitions for the terminal reply path: command codes, FSM states
// and the status-word layout, which the controller-side decoder also uses.
package reply_tx_ctrl_pkg;

    // Command codes carried on the link and echoed in the status word.
    typedef enum logic [1:0] {
        CMD_NONE = 2'b00,
        CMD_SR   = 2'b01,
        CMD_DPR  = 2'b10,
        CMD_CCW  = 2'b11
    } cmd_e;

    // Reply sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GAP    = 3'd1,
        ST_STATUS = 3'd2,
        ST_FETCH  = 3'd3,
        ST_DATA   = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    // Status-word bit positions.
    localparam int STS_ADDR_LSB = 11;
    localparam int STS_ADDR_W   = 5;
    localparam int STS_BUSY_BIT = 10;
    localparam int STS_ERR_BIT  = 9;
    localparam int STS_TYPE_LSB = 0;
    localparam int STS_TYPE_W   = 2;

    // Assemble a status word; bits not listed above are reserved zeros.
    function automatic logic [15:0] build_status(
        input logic [STS_ADDR_W-1:0] addr,
        input logic                  busy,
        input logic                  err,
        input cmd_e                  cmd
    );
        logic [15:0] w;
        w = '0;
        w[STS_ADDR_LSB +: STS_ADDR_W] = addr;
        w[STS_BUSY_BIT]               = busy;
        w[STS_ERR_BIT]                = err;
        w[STS_TYPE_LSB +: STS_TYPE_W] = cmd;
        return w;
    endfunction

endpackage

// File: rtl/reply_tx_ctrl_if.sv
// Word handshake between the reply controller and the serial transmitter.
interface reply_tx_ctrl_if;
    logic [15:0] tx_word;
    logic        tx_word_valid;
    logic        tx_last;
    logic        tx_word_ack;
    logic        tx_frame_done;

    // Reply controller side.
    modport master (
        output tx_word, tx_word_valid, tx_last,
        input  tx_word_ack, tx_frame_done
    );

    // Transmitter side.
    modport slave (
        input  tx_word, tx_word_valid, tx_last,
        output tx_word_ack, tx_frame_done
    );
endinterface

// File: rtl/reply_gap_timer.sv
// Turnaround timer: cleared and armed by i_start, then counts up and
// raises o_done for exactly one cycle when the count reaches GAP_TICKS.
module reply_gap_timer #(
    parameter int GAP_TICKS = 199
) (
    input  logic clk,
    input  logic n_rst,
    input  logic i_start,
    output logic o_done
);
    localparam int CW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

    logic [CW-1:0] r_cnt;
    logic          r_run;

    // Count while armed; disarm after the terminal count so done is one cycle.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (i_start) begin
            r_cnt <= '0;
            r_run <= 1'b1;
        end else if (r_run) begin
            if (r_cnt == CW'(GAP_TICKS)) r_run <= 1'b0;
            else                         r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_done = r_run && (r_cnt == CW'(GAP_TICKS));

endmodule

// File: rtl/reply_tx_ctrl.sv
// Terminal reply generator: detects a clean command frame, waits the
// turnaround gap, then hands the status word (and DPR payload) to the
// transmitter one word at a time. Errored frames are dropped unanswered.
module reply_tx_ctrl
    import reply_tx_ctrl_pkg::*;
#(
    parameter  int CLK_FREQ       = 50_000_000,
    parameter  int GAP_US         = 4,
    parameter  int MAX_DATA_WORDS = 16,
    localparam int DW             = $clog2(MAX_DATA_WORDS + 1)
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              i_rx_frame_end,
    input  logic              i_rx_err,
    input  logic [1:0]        i_rx_cmd_type,
    input  logic [4:0]        i_dev_addr,
    input  logic              i_dev_busy,
    input  logic [DW-1:0]     i_data_cnt,
    output logic [DW-1:0]     o_data_addr,
    input  logic [15:0]       i_data_word,
    reply_tx_ctrl_if.master   tx,
    output logic              o_ccw_exec,
    output logic              o_reply_active,
    output logic              o_cmd_dropped
);
    localparam int GAP_TICKS = CLK_FREQ / 1_000_000 * GAP_US - 1;

    state_e        r_state, w_next_state;
    logic          r_frame_end_d;
    cmd_e          r_type;
    logic          r_busy_l;
    logic [DW-1:0] r_n_l;
    logic          r_err_seen;
    logic [15:0]   r_status_word;
    logic [DW-1:0] r_data_addr;
    logic          r_ccw_exec;
    logic          r_cmd_dropped;
    logic          r_reply_active;

    logic          w_event;
    logic          w_accept;
    logic          w_drop;
    logic          w_err_set;
    logic          w_gap_done;
    logic          w_status_load;
    logic          w_clear_err;
    logic          w_addr_clear;
    logic          w_addr_inc;
    logic          w_reply_done;
    logic          w_more;
    logic          w_data_last;
    logic [DW-1:0] w_n_clamped;

    // A held rx_frame_end level produces a single event on its rising edge.
    assign w_event   = i_rx_frame_end && !r_frame_end_d;
    assign w_drop    = w_event && ((r_state != ST_IDLE) || i_rx_err);
    assign w_err_set = w_event && (r_state == ST_IDLE) && i_rx_err;

    assign w_n_clamped = (i_data_cnt > DW'(MAX_DATA_WORDS)) ? DW'(MAX_DATA_WORDS) : i_data_cnt;
    assign w_more      = (r_type == CMD_DPR) && !r_busy_l && (r_n_l != '0);
    assign w_data_last = (r_data_addr == r_n_l - DW'(1));

    reply_gap_timer #(
        .GAP_TICKS (GAP_TICKS)
    ) u_gap_timer (
        .clk     (clk),
        .n_rst   (n_rst),
        .i_start (w_accept),
        .o_done  (w_gap_done)
    );

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state decode and per-cycle control strobes.
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        w_next_state  = r_state;
        w_accept      = 1'b0;
        w_status_load = 1'b0;
        w_clear_err   = 1'b0;
        w_addr_clear  = 1'b0;
        w_addr_inc    = 1'b0;
        w_reply_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_event && !i_rx_err && (i_rx_cmd_type != CMD_NONE)) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_GAP;
                end
            end
            ST_GAP: begin
                if (w_gap_done) begin
                    w_status_load = 1'b1;
                    w_next_state  = ST_STATUS;
                end
            end
            ST_STATUS: begin
                if (tx.tx_word_ack) begin
                    w_clear_err = 1'b1;
                    if (w_more) begin
                        w_addr_clear = 1'b1;
                        w_next_state = ST_FETCH;
                    end else begin
                        w_next_state = ST_DONE;
                    end
                end
            end
            ST_FETCH: w_next_state = ST_DATA;
            ST_DATA: begin
                if (tx.tx_word_ack) begin
                    if (w_data_last) begin
                        w_next_state = ST_DONE;
                    end else begin
                        w_addr_inc   = 1'b1;
                        w_next_state = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                if (tx.tx_frame_done) begin
                    w_reply_done = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Command latches, error flag, status word, payload address and strobes.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_frame_end_d  <= 1'b0;
            r_type         <= CMD_NONE;
            r_busy_l       <= 1'b0;
            r_n_l          <= '0;
            r_err_seen     <= 1'b0;
            r_status_word  <= '0;
            r_data_addr    <= '0;
            r_ccw_exec     <= 1'b0;
            r_cmd_dropped  <= 1'b0;
            r_reply_active <= 1'b0;
        end else begin
            r_frame_end_d <= i_rx_frame_end;
            r_ccw_exec    <= w_accept && (cmd_e'(i_rx_cmd_type) == CMD_CCW) && !i_dev_busy;
            r_cmd_dropped <= w_drop;

            if (w_accept) begin
                r_type   <= cmd_e'(i_rx_cmd_type);
                r_busy_l <= i_dev_busy;
                r_n_l    <= w_n_clamped;
            end

            // A new error outranks the clear from a status-word ack.
            if (w_err_set)        r_err_seen <= 1'b1;
            else if (w_clear_err) r_err_seen <= 1'b0;

            // Snapshot the status word so it cannot move while awaiting ack.
            if (w_status_load)
                r_status_word <= build_status(i_dev_addr, r_busy_l, r_err_seen, r_type);

            if (w_addr_clear)    r_data_addr <= '0;
            else if (w_addr_inc) r_data_addr <= r_data_addr + 1'b1;

            if (w_accept)          r_reply_active <= 1'b1;
            else if (w_reply_done) r_reply_active <= 1'b0;
        end
    end

    // The payload word is the RAM's registered output and stays put while
    // data_addr holds, so the data path needs no extra holding register.
    assign tx.tx_word_valid = (r_state == ST_STATUS) || (r_state == ST_DATA);
    assign tx.tx_word       = (r_state == ST_STATUS) ? r_status_word :
                              (r_state == ST_DATA)   ? i_data_word   : 16'h0000;
    assign tx.tx_last       = (r_state == ST_STATUS) ? !w_more     :
                              (r_state == ST_DATA)   ? w_data_last : 1'b0;

    assign o_data_addr    = r_data_addr;
    assign o_ccw_exec     = r_ccw_exec;
    assign o_cmd_dropped  = r_cmd_dropped;
    assign o_reply_active = r_reply_active;

endmodule

// File: tb/tb_reply_tx_ctrl.sv
// Directed bench for reply_tx_ctrl: a table of single-command replies plus
// hand-written sequences for errors, held/overlapping frames and reset.
module tb_reply_tx_ctrl;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        rx_frame_end;
    logic        rx_err;
    logic [1:0]  rx_cmd_type;
    logic [4:0]  dev_addr;
    logic        dev_busy;
    logic [4:0]  data_cnt;
    logic [4:0]  data_addr;
    logic [15:0] data_word;
    logic        ccw_exec;
    logic        reply_active;
    logic        cmd_dropped;

    reply_tx_ctrl_if tx_bus ();

    reply_tx_ctrl dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .i_rx_frame_end (rx_frame_end),
        .i_rx_err       (rx_err),
        .i_rx_cmd_type  (rx_cmd_type),
        .i_dev_addr     (dev_addr),
        .i_dev_busy     (dev_busy),
        .i_data_cnt     (data_cnt),
        .o_data_addr    (data_addr),
        .i_data_word    (data_word),
        .tx             (tx_bus.master),
        .o_ccw_exec     (ccw_exec),
        .o_reply_active (reply_active),
        .o_cmd_dropped  (cmd_dropped)
    );

    always #5 clk = ~clk;

    // Payload RAM model: synchronous read, one cycle latency.
    logic [15:0] ram [32];
    always @(posedge clk) data_word <= ram[data_addr];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to 1 ns after the next rising edge; drive and sample there.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0]  cmd;
        logic        busy;
        logic [4:0]  addr;
        logic [4:0]  cnt;
        logic [15:0] exp_status;
        int          n_data;
        logic        exp_exec;
        int          ack_delay;
    } vec_t;

    vec_t vecs[9];

    task automatic ack_word();
        tx_bus.tx_word_ack = 1'b1;
        tick();
        tx_bus.tx_word_ack = 1'b0;
    endtask

    task automatic wait_valid(input int limit, output int n);
        n = 0;
        while (!tx_bus.tx_word_valid && n < limit) begin
            tick();
            n++;
        end
    endtask

    // Serve a reply whose triggering event happened 'elapsed' cycles ago.
    task automatic serve_reply(input vec_t v, input int elapsed);
        int  n;
        int  m;
        bit  stable;
        logic [15:0] exp_w;
        logic        exp_l;
        n = elapsed;
        while (!tx_bus.tx_word_valid && n < 400) begin
            tick();
            n++;
        end
        check("first_word_latency", n, 201);
        check("status_word", tx_bus.tx_word, v.exp_status);
        check("status_last", tx_bus.tx_last, (v.n_data == 0));
        stable = 1'b1;
        repeat (v.ack_delay) begin
            tick();
            if (!tx_bus.tx_word_valid || tx_bus.tx_word !== v.exp_status) stable = 1'b0;
        end
        if (v.ack_delay > 0) check("status_stable", stable, 1'b1);
        ack_word();
        for (int k = 0; k < v.n_data; k++) begin
            exp_w = ram[k];
            exp_l = (k == v.n_data - 1);
            wait_valid(4, m);
            check("data_valid", tx_bus.tx_word_valid, 1'b1);
            check($sformatf("data_word%0d", k), tx_bus.tx_word, exp_w);
            check($sformatf("data_last%0d", k), tx_bus.tx_last, exp_l);
            stable = 1'b1;
            repeat (v.ack_delay) begin
                tick();
                if (!tx_bus.tx_word_valid || tx_bus.tx_word !== exp_w || tx_bus.tx_last !== exp_l)
                    stable = 1'b0;
            end
            if (v.ack_delay > 0) check($sformatf("data_stable%0d", k), stable, 1'b1);
            ack_word();
        end
        check("done_valid_low", tx_bus.tx_word_valid, 1'b0);
        check("active_before_done", reply_active, 1'b1);
        tx_bus.tx_frame_done = 1'b1;
        tick();
        tx_bus.tx_frame_done = 1'b0;
        check("active_after_done", reply_active, 1'b0);
    endtask

    // Present one clean frame for a single cycle, then serve its reply.
    task automatic do_reply(input vec_t v);
        dev_addr     = v.addr;
        dev_busy     = v.busy;
        data_cnt     = v.cnt;
        rx_cmd_type  = v.cmd;
        rx_err       = 1'b0;
        rx_frame_end = 1'b1;
        tick();
        rx_frame_end = 1'b0;
        check("ccw_exec", ccw_exec, v.exp_exec);
        check("no_drop_on_accept", cmd_dropped, 1'b0);
        check("active_on_accept", reply_active, 1'b1);
        serve_reply(v, 1);
    endtask

    // Watch for a stretch of cycles and report whether any word was offered.
    task automatic watch_quiet(input int cycles, output bit quiet);
        quiet = 1'b1;
        repeat (cycles) begin
            tick();
            if (tx_bus.tx_word_valid) quiet = 1'b0;
        end
    endtask

    initial begin
        vec_t v;
        bit   flag;
        int   n;

        for (int i = 0; i < 32; i++) ram[i] = 16'h1000 + 16'(i);
        ram[0] = 16'h00A1;
        ram[1] = 16'h00B2;
        ram[2] = 16'h00C3;

        //          cmd    busy addr   cnt    status    n  exec delay
        vecs[0] = '{2'b01, 1'b0, 5'h0A, 5'd0,  16'h5001, 0,  1'b0, 0};
        vecs[1] = '{2'b10, 1'b0, 5'h0A, 5'd3,  16'h5002, 3,  1'b0, 5};
        vecs[2] = '{2'b11, 1'b0, 5'h0A, 5'd0,  16'h5003, 0,  1'b1, 1};
        vecs[3] = '{2'b11, 1'b1, 5'h0A, 5'd0,  16'h5403, 0,  1'b0, 0};
        vecs[4] = '{2'b10, 1'b1, 5'h0A, 5'd3,  16'h5402, 0,  1'b0, 0};
        vecs[5] = '{2'b10, 1'b0, 5'h0A, 5'd0,  16'h5002, 0,  1'b0, 0};
        vecs[6] = '{2'b10, 1'b0, 5'h0A, 5'd20, 16'h5002, 16, 1'b0, 0};
        vecs[7] = '{2'b01, 1'b1, 5'h1F, 5'd0,  16'hFC01, 0,  1'b0, 2};
        vecs[8] = '{2'b10, 1'b0, 5'h03, 5'd16, 16'h1802, 16, 1'b0, 1};

        n_rst                = 1'b0;
        rx_frame_end         = 1'b0;
        rx_err               = 1'b0;
        rx_cmd_type          = 2'b00;
        dev_addr             = 5'h0A;
        dev_busy             = 1'b0;
        data_cnt             = 5'd0;
        tx_bus.tx_word_ack   = 1'b0;
        tx_bus.tx_frame_done = 1'b0;
        repeat (3) tick();
        n_rst = 1'b1;
        tick();

        // Reset state.
        check("rst_valid", tx_bus.tx_word_valid, 1'b0);
        check("rst_word", tx_bus.tx_word, 16'h0000);
        check("rst_last", tx_bus.tx_last, 1'b0);
        check("rst_exec", ccw_exec, 1'b0);
        check("rst_active", reply_active, 1'b0);
        check("rst_dropped", cmd_dropped, 1'b0);
        check("rst_addr", data_addr, 5'd0);

        // Table of single-command replies.
        for (int i = 0; i < 9; i++) begin
            do_reply(vecs[i]);
            tick();
        end

        // Ignored frame type: no reply, no drop.
        rx_cmd_type  = 2'b00;
        rx_frame_end = 1'b1;
        tick();
        rx_frame_end = 1'b0;
        check("none_no_drop", cmd_dropped, 1'b0);
        check("none_not_active", reply_active, 1'b0);
        watch_quiet(220, flag);
        check("none_quiet", flag, 1'b1);

        // Errored frame: dropped, unanswered, flagged in the next status.
        rx_cmd_type  = 2'b01;
        rx_err       = 1'b1;
        rx_frame_end = 1'b1;
        tick();
        rx_frame_end = 1'b0;
        rx_err       = 1'b0;
        check("err_dropped", cmd_dropped, 1'b1);
        check("err_not_active", reply_active, 1'b0);
        tick();
        check("err_drop_one_cycle", cmd_dropped, 1'b0);
        watch_quiet(250, flag);
        check("err_quiet", flag, 1'b1);
        v = vecs[0];
        v.exp_status = 16'h5201;
        do_reply(v);
        tick();
        do_reply(vecs[0]);
        tick();

        // Held frame_end counts once; a second frame during GAP is dropped.
        v = vecs[0];
        dev_addr     = v.addr;
        dev_busy     = v.busy;
        rx_cmd_type  = v.cmd;
        rx_frame_end = 1'b1;
        flag = 1'b0;
        repeat (10) begin
            tick();
            if (cmd_dropped) flag = 1'b1;
        end
        rx_frame_end = 1'b0;
        check("held_no_drop", flag, 1'b0);
        repeat (40) tick();
        rx_frame_end = 1'b1;
        tick();
        rx_frame_end = 1'b0;
        check("gap_frame_dropped", cmd_dropped, 1'b1);
        serve_reply(v, 51);
        watch_quiet(250, flag);
        check("single_reply", flag, 1'b1);

        // Reset while the second payload word is on offer.
        dev_addr     = 5'h0A;
        dev_busy     = 1'b0;
        data_cnt     = 5'd3;
        rx_cmd_type  = 2'b10;
        rx_frame_end = 1'b1;
        tick();
        rx_frame_end = 1'b0;
        wait_valid(400, n);
        check("rstdata_status", tx_bus.tx_word, 16'h5002);
        ack_word();
        wait_valid(4, n);
        ack_word();
        wait_valid(4, n);
        check("rstdata_word2", tx_bus.tx_word, 16'h00B2);
        n_rst = 1'b0;
        #1;
        check("rstdata_valid", tx_bus.tx_word_valid, 1'b0);
        check("rstdata_word", tx_bus.tx_word, 16'h0000);
        check("rstdata_last", tx_bus.tx_last, 1'b0);
        check("rstdata_active", reply_active, 1'b0);
        check("rstdata_addr", data_addr, 5'd0);
        repeat (2) tick();
        n_rst = 1'b1;
        tick();
        do_reply(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the run always ends on its own.
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
